// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, instruction classes and the
// program-loader state encoding. The control-unit decoder uses the same
// opcode constants, so encoder and decoder cannot drift apart.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [2:0] {
    CLS_RTYPE = 3'd0,
    CLS_LW    = 3'd1,
    CLS_SW    = 3'd2,
    CLS_BEQ   = 3'd3,
    CLS_J     = 3'd4,
    CLS_ADDI  = 3'd5,
    CLS_RSV6  = 3'd6,
    CLS_RSV7  = 3'd7
  } instr_class_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

endpackage

// File: rtl/instr_word_encoder.sv
// Combinational packer: instruction class plus fields -> 32-bit MIPS word.
// class_valid is low for classes that have no encoding in this build.
// Build option: MIPS_ADDI_EN makes class 5 (addi) a valid class.
module instr_word_encoder
  import mips_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        class_valid
);

  instr_class_e cls_s;

  assign cls_s = instr_class_e'(cls);

  // Select the field layout for the class; unused fields are simply dropped.
  always_comb begin
    word        = 32'h0000_0000;
    class_valid = 1'b0;
    case (cls_s)
      CLS_RTYPE: begin
        word        = {OP_RTYPE, rs, rt, rd, shamt, funct};
        class_valid = 1'b1;
      end
      CLS_LW: begin
        word        = {OP_LW, rs, rt, imm};
        class_valid = 1'b1;
      end
      CLS_SW: begin
        word        = {OP_SW, rs, rt, imm};
        class_valid = 1'b1;
      end
      CLS_BEQ: begin
        word        = {OP_BEQ, rs, rt, imm};
        class_valid = 1'b1;
      end
      CLS_J: begin
        word        = {OP_J, target};
        class_valid = 1'b1;
      end
`ifdef MIPS_ADDI_EN
      CLS_ADDI: begin
        word        = {OP_ADDI, rs, rt, imm};
        class_valid = 1'b1;
      end
`else
      CLS_ADDI: begin
        word        = 32'h0000_0000;
        class_valid = 1'b0;
      end
`endif
      default: begin
        word        = 32'h0000_0000;
        class_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Program loader: accepts instruction descriptors over valid/ready, encodes
// each into a MIPS word and writes it to consecutive instruction-memory
// addresses starting at BASE_ADDR. A session ends on in_last or when the top
// word of memory has been written; the address never wraps.
// Build option: MIPS_ADDI_EN (passed through to instr_word_encoder).
module instr_encode_loader
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_TOP  = {ADDR_W{1'b1}};

  load_state_e       state_r, state_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic [ADDR_W:0]   count_r, count_nxt_s;
  logic              err_r, err_nxt_s;
  logic              we_r, we_nxt_s;
  logic [ADDR_W-1:0] waddr_r, waddr_nxt_s;
  logic [31:0]       wdata_r, wdata_nxt_s;
  logic [31:0]       word_s;
  logic              class_valid_s;
  logic              xfer_s;

  instr_word_encoder u_enc (
    .cls         (in_class),
    .rs          (in_rs),
    .rt          (in_rt),
    .rd          (in_rd),
    .shamt       (in_shamt),
    .funct       (in_funct),
    .imm         (in_imm),
    .target      (in_target),
    .word        (word_s),
    .class_valid (class_valid_s)
  );

  assign xfer_s = in_valid && (state_r == ST_LOAD);

  // Next-state, address/count bookkeeping and the write-port values.
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = addr_r;
    count_nxt_s = count_r;
    err_nxt_s   = err_r;
    we_nxt_s    = 1'b0;
    waddr_nxt_s = waddr_r;
    wdata_nxt_s = wdata_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s = ST_LOAD;
          addr_nxt_s  = ADDR_BASE;
          count_nxt_s = {(ADDR_W+1){1'b0}};
          err_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_LOAD: begin
        if (xfer_s) begin
          if (class_valid_s) begin
            we_nxt_s    = 1'b1;
            waddr_nxt_s = addr_r;
            wdata_nxt_s = word_s;
            count_nxt_s = count_r + {{ADDR_W{1'b0}}, 1'b1};
            if (addr_r == ADDR_TOP) begin
              // Top word written: the address holds, the session ends.
              addr_nxt_s = addr_r;
              if (!in_last) begin
                err_nxt_s = 1'b1;
              end else begin
                err_nxt_s = err_r;
              end
              state_nxt_s = ST_DONE;
            end else begin
              addr_nxt_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end else begin
            err_nxt_s = 1'b1;
          end
          if (in_last) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = (state_nxt_s == ST_DONE) ? ST_DONE : ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        addr_nxt_s  = ADDR_BASE;
      end
    endcase
  end

  // State and datapath registers; reset also drops any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      addr_r  <= ADDR_BASE;
      count_r <= {(ADDR_W+1){1'b0}};
      err_r   <= 1'b0;
      we_r    <= 1'b0;
      waddr_r <= {ADDR_W{1'b0}};
      wdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      addr_r  <= addr_nxt_s;
      count_r <= count_nxt_s;
      err_r   <= err_nxt_s;
      we_r    <= we_nxt_s;
      waddr_r <= waddr_nxt_s;
      wdata_r <= wdata_nxt_s;
    end
  end

  assign in_ready  = (state_r == ST_LOAD);
  assign busy      = (state_r == ST_LOAD);
  assign done      = (state_r == ST_DONE);
  assign err       = err_r;
  assign count     = count_r;
  assign mem_we    = we_r;
  assign mem_addr  = waddr_r;
  assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: a default instance (ADDR_W=8) and
// a small one (ADDR_W=2) share the same stimulus; the small one exercises
// the end-of-memory behaviour.
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [2:0]  in_class;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        a_ready, a_we, a_busy, a_done, a_err;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic [8:0]  a_count;

  logic        b_ready, b_we, b_busy, b_done, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encode_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(a_ready),
    .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .in_last(in_last), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .busy(a_busy), .done(a_done), .err(a_err), .count(a_count)
  );

  instr_encode_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(b_ready),
    .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .in_last(in_last), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .busy(b_busy), .done(b_done), .err(b_err), .count(b_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_class = 3'd0;
    in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0; in_funct = 6'd0;
    in_imm = 16'h0000; in_target = 26'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic put(input logic [2:0] c, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                     input logic [15:0] imm, input logic [25:0] tg, input logic last);
    in_valid = 1'b1; in_class = c; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_funct = fn; in_imm = imm; in_target = tg; in_last = last;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({a_we, a_addr, a_wdata, a_busy, a_done, a_err, a_count, a_ready} !== 54'd0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b addr=%h wdata=%h busy=%b done=%b err=%b count=%0d ready=%b required all zero",
               a_we, a_addr, a_wdata, a_busy, a_done, a_err, a_count, a_ready);
    end
    // Descriptors are refused in IDLE.
    put(3'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1, 26'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({a_we, a_count, a_ready} !== 11'd0) begin
      errors++;
      $display("FAIL idle_ignores got we=%b count=%0d ready=%b required 0 0 0", a_we, a_count, a_ready);
    end
  endtask

  task automatic test_rtype();
    do_reset();
    start_session();
    checks++;
    if ({a_ready, a_busy, a_done} !== 3'b110) begin
      errors++;
      $display("FAIL start_load got ready/busy/done=%b%b%b required 110", a_ready, a_busy, a_done);
    end
    put(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hABCD, 26'h3FFFFFF, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({a_we, a_addr, a_wdata, a_count} !== {1'b1, 8'h00, 32'h0022_1820, 9'd1}) begin
      errors++;
      $display("FAIL rtype_write got we=%b addr=%h wdata=%h count=%0d required 1 00 00221820 1",
               a_we, a_addr, a_wdata, a_count);
    end
    // Write strobe is a single-cycle pulse; start in LOAD is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({a_we, a_count, a_busy} !== {1'b0, 9'd1, 1'b1}) begin
      errors++;
      $display("FAIL pulse_and_start_ignored got we=%b count=%0d busy=%b required 0 1 1", a_we, a_count, a_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h8FA8_0004; exp_w[1] = 32'hAFA8_0000;
    exp_w[2] = 32'h1022_FFFF; exp_w[3] = 32'h0810_0000;
    do_reset();
    start_session();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: put(3'd1, 5'd29, 5'd8, 5'd7, 5'd3, 6'h3F, 16'h0004, 26'h0, 1'b0);
        1: put(3'd2, 5'd29, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0, 1'b0);
        2: put(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'hFFFF, 26'h0, 1'b0);
        default: put(3'd4, 5'd31, 5'd31, 5'd0, 5'd0, 6'h00, 16'hFFFF, 26'h0100000, 1'b1);
      endcase
      tick();
      checks++;
      if ({a_we, a_addr, a_wdata} !== {1'b1, 8'(i), exp_w[i]}) begin
        errors++;
        $display("FAIL b2b_write%0d got we=%b addr=%h wdata=%h required 1 %h %h",
                 i, a_we, a_addr, a_wdata, 8'(i), exp_w[i]);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if ({a_done, a_busy, a_ready, a_count, a_err} !== {3'b100, 9'd4, 1'b0}) begin
      errors++;
      $display("FAIL b2b_done got done=%b busy=%b ready=%b count=%0d err=%b required 1 0 0 4 0",
               a_done, a_busy, a_ready, a_count, a_err);
    end
    tick();
    checks++;
    if ({a_we, a_done} !== 2'b01) begin
      errors++;
      $display("FAIL done_held got we=%b done=%b required 0 1", a_we, a_done);
    end
    // Restart from DONE clears count and err.
    start_session();
    checks++;
    if ({a_busy, a_done, a_count, a_err} !== {2'b10, 9'd0, 1'b0}) begin
      errors++;
      $display("FAIL restart got busy=%b done=%b count=%0d err=%b required 1 0 0 0", a_busy, a_done, a_count, a_err);
    end
  endtask

  task automatic test_invalid_class();
    int writes = 0;
    logic [7:0] waddr [2];
    do_reset();
    start_session();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) put(3'd6, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'h1234, 26'h1, 1'b0);
      else        put(3'd1, 5'd0, 5'd9, 5'd0, 5'd0, 6'd0, 16'h0010, 26'h0, 1'b0);
      tick();
      if (a_we) begin
        if (writes < 2) waddr[writes] = a_addr;
        writes++;
      end
    end
    in_valid = 1'b0;
    tick();
    if (a_we) writes++;
    checks++;
    if (writes != 2 || waddr[0] !== 8'h00 || waddr[1] !== 8'h01) begin
      errors++;
      $display("FAIL invalid_writes got writes=%0d addr0=%h addr1=%h required 2 00 01", writes, waddr[0], waddr[1]);
    end
    checks++;
    if ({a_err, a_count, a_busy} !== {1'b1, 9'd2, 1'b1}) begin
      errors++;
      $display("FAIL invalid_err got err=%b count=%0d busy=%b required 1 2 1", a_err, a_count, a_busy);
    end
    // Invalid class with in_last still ends the session.
    put(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0, 1'b1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if ({a_we, a_done, a_count} !== {2'b01, 9'd2}) begin
      errors++;
      $display("FAIL invalid_last got we=%b done=%b count=%0d required 0 1 2", a_we, a_done, a_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    start_session();
    for (int i = 0; i < 4; i++) begin
      put(3'd1, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'(i), 26'h0, 1'b0);
      tick();
      checks++;
      if ({b_we, b_addr, b_wdata} !== {1'b1, 2'(i), 32'h8C43_0000 | 32'(i)}) begin
        errors++;
        $display("FAIL ovf_write%0d got we=%b addr=%h wdata=%h required 1 %h %h",
                 i, b_we, b_addr, b_wdata, 2'(i), 32'h8C43_0000 | 32'(i));
      end
    end
    in_valid = 1'b0;
    checks++;
    if ({b_done, b_err, b_count, b_ready} !== {2'b11, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL ovf_done got done=%b err=%b count=%0d ready=%b required 1 1 4 0", b_done, b_err, b_count, b_ready);
    end
    put(3'd1, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({b_we, b_count, b_ready} !== {1'b0, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL ovf_no_wrap got we=%b count=%0d ready=%b required 0 4 0", b_we, b_count, b_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    start_session();
    put(3'd2, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'h0008, 26'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    // A transfer presented together with reset must not write.
    put(3'd1, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'h000C, 26'h0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({a_we, a_addr, a_wdata, a_busy, a_done, a_err, a_count, a_ready} !== 54'd0) begin
      errors++;
      $display("FAIL reset_mid_load got we=%b addr=%h wdata=%h busy=%b count=%0d ready=%b required all zero",
               a_we, a_addr, a_wdata, a_busy, a_count, a_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({a_we, a_ready, a_count} !== 11'd0) begin
      errors++;
      $display("FAIL reset_stays_idle got we=%b ready=%b count=%0d required 0 0 0", a_we, a_ready, a_count);
    end
  endtask

  task automatic test_addi();
    do_reset();
    start_session();
    put(3'd5, 5'd0, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0007, 26'h0, 1'b0);
    tick();
    in_valid = 1'b0;
`ifdef MIPS_ADDI_EN
    checks++;
    if ({a_we, a_addr, a_wdata, a_err, a_count} !== {1'b1, 8'h00, 32'h2004_0007, 1'b0, 9'd1}) begin
      errors++;
      $display("FAIL addi_enabled got we=%b addr=%h wdata=%h err=%b count=%0d required 1 00 20040007 0 1",
               a_we, a_addr, a_wdata, a_err, a_count);
    end
`else
    checks++;
    if ({a_we, a_err, a_count} !== {2'b01, 9'd0}) begin
      errors++;
      $display("FAIL addi_disabled got we=%b err=%b count=%0d required 0 1 0", a_we, a_err, a_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_back_to_back();
    test_invalid_class();
    test_overflow();
    test_reset_mid_load();
    test_addi();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
